// File: rtl/disp_median3x3.sv
// disp_median3x3: 3x3 median filter for a raster-order disparity stream.
//
// Ports
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   clken        : global clock enable; all state and outputs hold while low
//   enable       : 1 = median filtering, 0 = bypass (sampled at frame start)
//   width/height : image size, sampled on the first transfer of a frame
//   valid_in/din : input pixel stream (transfer = valid_in && ready_in && clken)
//   ready_in     : high in IDLE and RUN, low while the last row is flushed
//   valid_out    : one-cycle pulse per output pixel
//   dout         : filtered disparity, raster order
//   frame_end    : high with valid_out on the last pixel of a frame
//
// Handshake: a pixel moves only on a rising edge where valid_in, ready_in and
// clken are all high; ready_in never depends on valid_in. Outputs are
// consumed on the rising edge where valid_out and clken are both high.
//
// The output for centre (r-1,c-1) is produced by the transfer of (r,c), so
// the output stream lags the input by W+1 pixels; FLUSH supplies the last
// W+1 slots with no input. Each incoming column (two line-buffer reads plus
// din) is sorted as it enters the window, and the registered sorted columns
// are merged into the median on the next edge: two register stages.
module disp_median3x3 #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              enable,
  input  logic [AWIDTH-1:0] width,
  input  logic [AWIDTH-1:0] height,
  input  logic              valid_in,
  input  logic [DWIDTH-1:0] din,
  output logic              ready_in,
  output logic              valid_out,
  output logic [DWIDTH-1:0] dout,
  output logic              frame_end
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [AWIDTH-1:0] ONE   = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] THREE = AWIDTH'(3);
  localparam int                DEPTH = 1 << AWIDTH;

  state_t            state, state_nx;
  logic [AWIDTH-1:0] w_reg, h_reg;   // frame size latched at frame start
  logic              byp_reg;        // frame runs in bypass
  logic [AWIDTH-1:0] col, row;       // position of the last transfer
  logic [AWIDTH-1:0] cc, cr;         // next centre to emit (median mode)
  logic [AWIDTH-1:0] fc;             // flush slot counter 0..W

  logic [DWIDTH-1:0] lb1 [DEPTH];    // row r-1
  logic [DWIDTH-1:0] lb2 [DEPTH];    // row r-2

  // Window of sorted columns (index 2 newest) plus the raw middle-row value
  // of each column, which is what border centres pass through.
  logic [DWIDTH-1:0] lo_w [3];
  logic [DWIDTH-1:0] md_w [3];
  logic [DWIDTH-1:0] hi_w [3];
  logic [DWIDTH-1:0] ctr_w [3];
  logic              s_valid, s_pass, s_last;

  logic              idle, xfer, flushing, byp_eff, last_xfer;
  logic              slot, shift, slot_pass, slot_last;
  logic [AWIDTH-1:0] w_eff, h_eff, pos_c, pos_r, lb_addr;
  logic [DWIDTH-1:0] col_top, col_mid;

  function automatic logic [DWIDTH-1:0] min3(input logic [DWIDTH-1:0] a, b, c);
    logic [DWIDTH-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [DWIDTH-1:0] max3(input logic [DWIDTH-1:0] a, b, c);
    logic [DWIDTH-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [DWIDTH-1:0] med3(input logic [DWIDTH-1:0] a, b, c);
    logic [DWIDTH-1:0] lo, hi, t;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    t  = (hi < c) ? hi : c;
    return (lo > t) ? lo : t;
  endfunction

  assign idle     = (state == IDLE);
  assign ready_in = (state != FLUSH);
  assign xfer     = valid_in && ready_in && clken;
  assign flushing = (state == FLUSH) && clken;
  // In IDLE the frame parameters come straight from the ports, since the
  // first transfer is the one that latches them.
  assign w_eff    = idle ? width  : w_reg;
  assign h_eff    = idle ? height : h_reg;
  assign byp_eff  = idle ? (!enable || (width < THREE) || (height < THREE)) : byp_reg;

  always_comb begin
    pos_c = '0;
    pos_r = '0;
    if (!idle) begin
      if (col == w_reg - ONE) begin
        pos_c = '0;
        pos_r = row + ONE;
      end else begin
        pos_c = col + ONE;
        pos_r = row;
      end
    end
  end

  assign last_xfer = (pos_r == h_eff - ONE) && (pos_c == w_eff - ONE);
  assign shift     = !byp_eff && (xfer || flushing);
  // FLUSH walks a virtual row below the image; its bottom values only reach
  // border centres, so din is a harmless filler there.
  assign lb_addr   = (state == FLUSH) ? fc : pos_c;
  assign col_top   = lb2[lb_addr];
  assign col_mid   = lb1[lb_addr];

  always_comb begin
    slot      = flushing;
    slot_pass = 1'b1;
    slot_last = 1'b0;
    if (xfer && (byp_eff || (pos_r > ONE) || ((pos_r == ONE) && (pos_c != '0))))
      slot = 1'b1;
    if (byp_eff) begin
      slot_last = last_xfer;
    end else begin
      slot_pass = (cr == '0) || (cr == h_reg - ONE) || (cc == '0) || (cc == w_reg - ONE);
      slot_last = (cr == h_reg - ONE) && (cc == w_reg - ONE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xfer) state_nx = (byp_eff && last_xfer) ? IDLE : RUN;
      RUN:     if (xfer && last_xfer) state_nx = byp_reg ? IDLE : FLUSH;
      FLUSH:   if (clken && (fc == w_reg)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      lb1[pos_c] <= din;
      lb2[pos_c] <= lb1[pos_c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      w_reg     <= '0;
      h_reg     <= '0;
      byp_reg   <= 1'b0;
      col       <= '0;
      row       <= '0;
      cc        <= '0;
      cr        <= '0;
      fc        <= '0;
      for (int i = 0; i < 3; i++) begin
        lo_w[i]  <= '0;
        md_w[i]  <= '0;
        hi_w[i]  <= '0;
        ctr_w[i] <= '0;
      end
      s_valid   <= 1'b0;
      s_pass    <= 1'b0;
      s_last    <= 1'b0;
      valid_out <= 1'b0;
      frame_end <= 1'b0;
      dout      <= '0;
    end else if (clken) begin
      state <= state_nx;
      if (xfer) begin
        col <= pos_c;
        row <= pos_r;
        if (idle) begin
          w_reg   <= width;
          h_reg   <= height;
          byp_reg <= byp_eff;
        end
      end
      if (idle && xfer) begin
        cc <= '0;
        cr <= '0;
      end else if (slot && !byp_eff) begin
        if (cc == w_reg - ONE) begin
          cc <= '0;
          cr <= cr + ONE;
        end else begin
          cc <= cc + ONE;
        end
      end
      if (xfer && last_xfer) fc <= '0;
      else if (flushing)     fc <= fc + ONE;

      if (shift) begin
        lo_w[0]  <= lo_w[1];  lo_w[1]  <= lo_w[2];  lo_w[2]  <= min3(col_top, col_mid, din);
        md_w[0]  <= md_w[1];  md_w[1]  <= md_w[2];  md_w[2]  <= med3(col_top, col_mid, din);
        hi_w[0]  <= hi_w[1];  hi_w[1]  <= hi_w[2];  hi_w[2]  <= max3(col_top, col_mid, din);
        ctr_w[0] <= ctr_w[1]; ctr_w[1] <= ctr_w[2]; ctr_w[2] <= col_mid;
      end else if (xfer && byp_eff) begin
        ctr_w[1] <= din;
      end
      s_valid <= slot;
      s_pass  <= slot_pass;
      s_last  <= slot_last;

      // Median of 9 = med3(max of column minima, med of column medians,
      // min of column maxima).
      valid_out <= s_valid;
      frame_end <= s_valid && s_last;
      if (s_valid)
        dout <= s_pass ? ctr_w[1]
                       : med3(max3(lo_w[0], lo_w[1], lo_w[2]),
                              med3(md_w[0], md_w[1], md_w[2]),
                              min3(hi_w[0], hi_w[1], hi_w[2]));
    end
  end

endmodule

// File: tb/tb_disp_median3x3.sv
// tb_disp_median3x3: directed bench for disp_median3x3 with a reference model
// that computes every output pixel straight from the frame contents.
module tb_disp_median3x3;
  localparam int DW = 16;
  localparam int AW = 11;

  logic          clk, rst, clken, enable, valid_in;
  logic [AW-1:0] width, height;
  logic [DW-1:0] din;
  logic          ready_in, valid_out, frame_end;
  logic [DW-1:0] dout;

  disp_median3x3 #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clken(clken), .enable(enable),
    .width(width), .height(height), .valid_in(valid_in), .din(din),
    .ready_in(ready_in), .valid_out(valid_out), .dout(dout), .frame_end(frame_end)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic          exp_fe_q[$];
  int            exp_cyc_q[$];

  int pix[256];
  int mdl[256];
  int out_log[256];
  int ref_log[256];
  int log_n  = 0;
  int fe_cnt = 0;
  int en_cyc = 0;

  int mon_w = 1, mon_h = 1;
  bit mon_byp = 1'b0;
  int xfer_n = 0;
  bit fl_track = 1'b0;
  int fl_cnt = 0, fl_exp = 0;

  bit gaps_on = 1'b0;
  bit clk_tog = 1'b0;

  task automatic check(input string nm, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_frame(input int w, input int h, input bit en);
    int v[9];
    int k, t, r, c, e;
    bit byp;
    byp = !en || (w < 3) || (h < 3);
    for (int i = 0; i < w * h; i++) begin
      r = i / w;
      c = i % w;
      if (byp || r == 0 || r == h - 1 || c == 0 || c == w - 1) begin
        e = pix[i];
      end else begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            v[k] = pix[(r + dr) * w + c + dc];
            k++;
          end
        for (int a = 0; a < 9; a++)
          for (int b = 0; b < 8 - a; b++)
            if (v[b] > v[b + 1]) begin
              t = v[b]; v[b] = v[b + 1]; v[b + 1] = t;
            end
        e = v[4];
      end
      mdl[i] = e;
      exp_q.push_back(DW'(e));
      exp_fe_q.push_back(i == w * h - 1);
    end
  endtask

  // ---------------- clken driver ----------------
  initial begin
    clken = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      clken = clk_tog ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- pixel driver ----------------
  task automatic drive_frame(input int w, input int h, input bit en, input int npx);
    int  guard;
    bit  got;
    width   = AW'(w);
    height  = AW'(h);
    enable  = en;
    mon_w   = w;
    mon_h   = h;
    mon_byp = !en || (w < 3) || (h < 3);
    model_frame(w, h, en);
    for (int i = 0; i < npx; i++) begin
      din   = DW'(pix[i]);
      got   = 1'b0;
      guard = 0;
      while (!got && guard < 400) begin
        valid_in = gaps_on ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(negedge clk);
        got = valid_in && ready_in && clken;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!got) begin
        n_checks++;
        n_fail++;
        $display("FAIL drive_timeout: pixel %0d not accepted within %0d cycles", i, guard);
        valid_in = 1'b0;
        return;
      end
      // Mid-frame parameter changes must have no effect.
      if (i == 0) begin
        width  = AW'($urandom_range(1, 30));
        height = AW'($urandom_range(1, 30));
        enable = $urandom_range(0, 1);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || fl_track) && g < 3000) begin
      @(posedge clk);
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size() + int'(fl_track), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [DW-1:0] e;
    logic          fe;
    int            cy;
    if (!rst && clken) begin
      if (fl_track) begin
        if (!ready_in) fl_cnt++;
        else begin
          check("flush_len", fl_cnt, fl_exp);
          fl_track = 1'b0;
        end
      end
      if (valid_in && ready_in) begin
        if (mon_byp || xfer_n >= mon_w + 1) exp_cyc_q.push_back(en_cyc + 2);
        xfer_n++;
        if (xfer_n == mon_w * mon_h) begin
          if (!mon_byp)
            for (int j = 1; j <= mon_w + 1; j++) exp_cyc_q.push_back(en_cyc + j + 2);
          fl_track = 1'b1;
          fl_cnt   = 0;
          fl_exp   = mon_byp ? 0 : mon_w + 1;
          xfer_n   = 0;
        end
      end
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_valid_out: got dout %0d with no output expected", dout);
        end else begin
          e  = exp_q.pop_front();
          fe = exp_fe_q.pop_front();
          cy = (exp_cyc_q.size() != 0) ? exp_cyc_q.pop_front() : -1;
          check("dout", dout, e);
          check("frame_end", frame_end, fe);
          check("latency_cycle", en_cyc, cy);
          if (log_n < 256) out_log[log_n] = int'(dout);
          log_n++;
        end
        if (frame_end) fe_cnt++;
      end
      en_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int fe0, diff;
    int f1[9];
    int f2[9];
    f1 = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    f2 = '{100, 0, 0, 0, 50, 0, 0, 0, 0};

    rst = 1'b1; enable = 1'b1; width = AW'(4); height = AW'(3);
    valid_in = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_in", ready_in, 1);
    check("reset_valid_out", valid_out, 0);
    check("reset_dout", dout, 0);
    check("reset_frame_end", frame_end, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 4x3 ramp, median on
    for (int i = 0; i < 12; i++) pix[i] = i;
    log_n = 0; fe0 = fe_cnt;
    drive_frame(4, 3, 1'b1, 12);
    drain();
    check("a_model_centre_1_1", mdl[5], 5);
    check("a_model_centre_1_2", mdl[6], 6);
    check("a_dut_centre_1_1", out_log[5], 5);
    check("a_dut_centre_1_2", out_log[6], 6);
    check("a_dut_border_0_3", out_log[3], 3);
    check("a_dut_last", out_log[11], 11);
    check("a_out_count", log_n, 12);
    check("a_frame_end_count", fe_cnt - fe0, 1);

    // 5x5 flat field with a centre spike
    for (int i = 0; i < 25; i++) pix[i] = 7;
    pix[12] = 200;
    log_n = 0;
    drive_frame(5, 5, 1'b1, 25);
    drain();
    check("b_model_spike", mdl[12], 7);
    check("b_dut_spike", out_log[12], 7);
    check("b_out_count", log_n, 25);

    // 4x3 ramp, bypass
    for (int i = 0; i < 12; i++) pix[i] = i;
    log_n = 0;
    drive_frame(4, 3, 1'b0, 12);
    drain();
    check("c_dut_pixel_5", out_log[5], 5);
    check("c_dut_pixel_10", out_log[10], 10);
    check("c_out_count", log_n, 12);

    // 16x4 random frame, clean run then gaps + clken toggling
    for (int i = 0; i < 64; i++) pix[i] = $urandom_range(0, 65535);
    log_n = 0;
    drive_frame(16, 4, 1'b1, 64);
    drain();
    for (int i = 0; i < 64; i++) ref_log[i] = out_log[i];
    log_n = 0;
    gaps_on = 1'b1; clk_tog = 1'b1;
    drive_frame(16, 4, 1'b1, 64);
    drain();
    gaps_on = 1'b0; clk_tog = 1'b0;
    @(posedge clk); #1;
    diff = 0;
    for (int i = 0; i < 64; i++) if (out_log[i] != ref_log[i]) diff++;
    check("d_stream_equal", diff, 0);
    check("d_out_count", log_n, 64);

    // Reset in the middle of an 8x8 frame
    for (int i = 0; i < 64; i++) pix[i] = $urandom_range(1, 65535);
    drive_frame(8, 8, 1'b1, 10);
    rst = 1'b1;
    #1;
    check("e_rst_valid_out", valid_out, 0);
    check("e_rst_dout", dout, 0);
    check("e_rst_frame_end", frame_end, 0);
    check("e_rst_ready_in", ready_in, 1);
    exp_q.delete(); exp_fe_q.delete(); exp_cyc_q.delete();
    xfer_n = 0; fl_track = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) pix[i] = $urandom_range(0, 65535);
    log_n = 0;
    drive_frame(4, 3, 1'b1, 12);
    drain();
    check("e_out_count", log_n, 12);

    // Two 3x3 frames back to back
    log_n = 0; fe0 = fe_cnt;
    for (int i = 0; i < 9; i++) pix[i] = f1[i];
    drive_frame(3, 3, 1'b1, 9);
    for (int i = 0; i < 9; i++) pix[i] = f2[i];
    drive_frame(3, 3, 1'b1, 9);
    drain();
    check("f_frame1_median", out_log[4], 5);
    check("f_frame1_border", out_log[0], 9);
    check("f_frame2_median", out_log[13], 0);
    check("f_frame2_border", out_log[9], 100);
    check("f_out_count", log_n, 18);
    check("f_frame_end_count", fe_cnt - fe0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
